commit_trace_buffer: RTL
========================

// Module: commit_trace_buffer
// PURPOSE
//  Circular trace buffer of retired instructions, tapped from the MEM/WB writeback point of the core.
//  Parametrised in depth and data width, with arm/trigger/post-trigger-freeze control.
//  Supports random-access readout of the frozen history.
//  Gives benches and on-chip debug a cycle-accurate commit log without $display dumps of every stage.
// PARAMETERS
//  DEPTH       64  entries held; power of 2, >=4
//  XLEN        32  width of PC and writeback data
//  STOP_AFTER  16  entries captured after the trigger entry before freezing; 0..DEPTH-1
// PORTS
//  clk                 in   1              clock; all state changes on posedge
//  reset               in   1              synchronous, active-high
//  in_valid            in   1              one instruction retires this cycle
//  in_PC               in   XLEN           PC of retiring instruction
//  in_instruction      in   32             instruction word
//  in_rd               in   5              destination register
//  in_write_enable     in   1              regWrite of retiring instruction
//  in_write_data       in   XLEN           writeback value
//  in_arm              in   1              pulse: clear buffer, start capture
//  in_trigger_en       in   1              enable PC-match trigger
//  in_trigger_PC       in   XLEN           trigger PC
//  in_rd_addr          in   $clog2(DEPTH)  readout index, 0 = oldest entry
//  out_rd_valid        out  1              in_rd_addr < out_count (registered)
//  out_rd_PC           out  XLEN           entry PC
//  out_rd_instruction  out  32             entry instruction
//  out_rd_rd           out  5              entry rd
//  out_rd_write_enable out  1              entry regWrite
//  out_rd_write_data   out  XLEN           entry writeback data
//  out_state           out  2              00 IDLE, 01 CAPTURE, 10 POST, 11 FROZEN
//  out_count           out  $clog2(DEPTH+1) valid entries, saturates at DEPTH
//  out_triggered       out  1              trigger has fired since last arm
// BEHAVIOUR
//  - Reset: state IDLE, wr_ptr=0, count=0, post_cnt=0.
//    out_triggered=0. All out_rd_* = 0.
//  - IDLE: no capture. in_arm -> CAPTURE.
//  - CAPTURE: each in_valid writes the entry at wr_ptr.
//    wr_ptr+=1 mod DEPTH; count+=1, saturating at DEPTH.
//    Once full, the oldest entry is overwritten.
//  - Trigger: in_trigger_en & in_valid & in_PC==in_trigger_PC while in CAPTURE.
//    The triggering entry is captured; out_triggered<=1.
//    If STOP_AFTER==0 -> FROZEN, else -> POST with post_cnt=STOP_AFTER.
//  - POST: each in_valid captures and decrements post_cnt.
//    The capture that brings post_cnt to 0 moves to FROZEN on the same edge.
//    Further PC matches are ignored.
//  - FROZEN: no writes. Contents are held until in_arm or reset.
//  - in_arm in any state: state<=CAPTURE; wr_ptr, count, post_cnt, out_triggered <= 0.
//    A same-cycle in_valid is NOT captured (arm wins).
//  - reset mid-capture: same as reset; contents need not be cleared (count=0 hides them).
//  - Stored write_enable is forced to 0 when in_rd==0.
//  - Readout: physical index = (wr_ptr - count + in_rd_addr) mod DEPTH.
//    Registered, 1-cycle latency, valid in every state.
//    out_rd_valid=0 -> out_rd_* = 0.
//    A read of the slot being written in the same cycle returns the old content.
// CONFIGURATION
//  TRACE_FILTER_EN defined: adds inputs in_filter_lo and in_filter_hi (XLEN each).
//    In CAPTURE/POST, only retirements with in_filter_lo <= in_PC <= in_filter_hi (unsigned) are captured.
//    The trigger and post_cnt decrement consider captured entries only.
//  TRACE_FILTER_EN undefined: the ports are absent; every in_valid retirement is captured.
// TESTING
//  1 reset, then 3 cycles idle with in_valid=1 -> out_state=00, out_count=0, out_rd_valid=0.
//  2 arm; 5 retirements at PC 0x80,0x84,0x88,0x8c,0x90 -> out_count=5.
//    Read idx 0 -> PC 0x80 one cycle later; read idx 4 -> PC 0x90.
//  3 DEPTH=64, 70 retirements of loop body -> out_count=64.
//    Idx 0 holds the 7th retirement; idx 63 holds the 70th.
//  4 STOP_AFTER=2, trigger_PC=0x88 on the loop_add_bne stream:
//    - freezes 2 entries after the first 0x88: out_state=11, out_triggered=1.
//    - the newest entry is the bne at 0x90.
//    - later retirements do not change out_count.
//  5 in_arm and in_valid together in FROZEN -> state 01, count 0; that entry is not captured.
//  6 retire addi x0,x0,0 with in_write_enable=1 -> stored write_enable=0.
//    With TRACE_FILTER_EN and lo=0x84, hi=0x88 -> only PCs 0x84, 0x88 are captured.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: circular commit log with arm/trigger/post-trigger freeze and random-access readout.
// Define TRACE_FILTER_EN to add an inclusive PC window (in_filter_lo..in_filter_hi) on captures.
module commit_trace_buffer #(
  parameter int DEPTH      = 64,
  parameter int XLEN       = 32,
  parameter int STOP_AFTER = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_PC,
  input  logic [31:0]                in_instruction,
  input  logic [4:0]                 in_rd,
  input  logic                       in_write_enable,
  input  logic [XLEN-1:0]            in_write_data,
  input  logic                       in_arm,
  input  logic                       in_trigger_en,
  input  logic [XLEN-1:0]            in_trigger_PC,
`ifdef TRACE_FILTER_EN
  input  logic [XLEN-1:0]            in_filter_lo,
  input  logic [XLEN-1:0]            in_filter_hi,
`endif
  input  logic [$clog2(DEPTH)-1:0]   in_rd_addr,
  output logic                       out_rd_valid,
  output logic [XLEN-1:0]            out_rd_PC,
  output logic [31:0]                out_rd_instruction,
  output logic [4:0]                 out_rd_rd,
  output logic                       out_rd_write_enable,
  output logic [XLEN-1:0]            out_rd_write_data,
  output logic [1:0]                 out_state,
  output logic [$clog2(DEPTH+1)-1:0] out_count,
  output logic                       out_triggered
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2*XLEN + 38;
  localparam logic [1:0] IDLE = 2'b00, CAPTURE = 2'b01, POST = 2'b10, FROZEN = 2'b11;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, post_cnt, rd_idx;
  logic filter_ok, capture, trig, rd_hit;
  logic [EW-1:0] entry;
`ifdef TRACE_FILTER_EN
  assign filter_ok = (in_PC >= in_filter_lo) && (in_PC <= in_filter_hi);
`else
  assign filter_ok = 1'b1;
`endif
  assign capture = in_valid && filter_ok && (out_state == CAPTURE || out_state == POST);
  assign trig    = capture && out_state == CAPTURE && in_trigger_en && in_PC == in_trigger_PC;
  assign entry   = {in_PC, in_instruction, in_rd, in_write_enable && in_rd != 5'd0, in_write_data};
  // A full buffer has count[AW-1:0]==0, so wr_ptr itself is the oldest slot.
  assign rd_idx  = wr_ptr - out_count[AW-1:0] + in_rd_addr;
  assign rd_hit  = {1'b0, in_rd_addr} < out_count;
  always_ff @(posedge clk)
    if (capture && !in_arm) mem[wr_ptr] <= entry;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state     <= IDLE;
      wr_ptr        <= '0;
      out_count     <= '0;
      post_cnt      <= '0;
      out_triggered <= 1'b0;
    end else if (in_arm) begin
      out_state     <= CAPTURE;
      wr_ptr        <= '0;
      out_count     <= '0;
      post_cnt      <= '0;
      out_triggered <= 1'b0;
    end else if (capture) begin
      wr_ptr    <= wr_ptr + AW'(1);
      out_count <= out_count == CW'(DEPTH) ? out_count : out_count + CW'(1);
      if (trig) begin
        out_triggered <= 1'b1;
        out_state     <= STOP_AFTER == 0 ? FROZEN : POST;
        post_cnt      <= AW'(STOP_AFTER);
      end else if (out_state == POST) begin
        post_cnt  <= post_cnt - AW'(1);
        out_state <= post_cnt == AW'(1) ? FROZEN : POST;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_rd_valid <= 1'b0;
      {out_rd_PC, out_rd_instruction, out_rd_rd, out_rd_write_enable, out_rd_write_data} <= '0;
    end else begin
      out_rd_valid <= rd_hit;
      {out_rd_PC, out_rd_instruction, out_rd_rd, out_rd_write_enable, out_rd_write_data} <= rd_hit ? mem[rd_idx] : '0;
    end
  end
endmodule
